// File: rtl/conv_l1_ctrl.sv
// Layer-1 convolution sequencer: walks a z/y/x tile loop and hands each tile
// first to the memory reader and then to the PE array, waiting for each to finish.
module conv_l1_ctrl #(
  parameter int X_STEPS  = 4,
  parameter int Y_STEPS  = 4,
  parameter int Z_STEPS  = 2,
  parameter int X_STRIDE = 4,
  parameter int Y_STRIDE = 4,
  parameter int Z_STRIDE = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        done_mem_l1,
  input  logic        done_pe_l1,
  output logic        start_mem_l1,
  output logic        start_pe_l1,
  output logic [7:0]  x,
  output logic [7:0]  y,
  output logic [7:0]  z,
  output logic [15:0] tile_cnt,
  output logic        busy,
  output logic        done
);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    MEM_GO   = 3'd1,
    MEM_WAIT = 3'd2,
    PE_GO    = 3'd3,
    PE_WAIT  = 3'd4,
    ADV      = 3'd5,
    FIN      = 3'd6
  } state_e;

  localparam logic [15:0] X_LAST = 16'(X_STEPS - 1);
  localparam logic [15:0] Y_LAST = 16'(Y_STEPS - 1);
  localparam logic [15:0] Z_LAST = 16'(Z_STEPS - 1);
  localparam logic [7:0]  X_INC  = 8'(X_STRIDE);
  localparam logic [7:0]  Y_INC  = 8'(Y_STRIDE);
  localparam logic [7:0]  Z_INC  = 8'(Z_STRIDE);

  state_e      state_q, state_d;
  logic [15:0] xi_q, xi_d, yi_q, yi_d, zi_q, zi_d;
  logic [7:0]  x_q, x_d, y_q, y_d, z_q, z_d;
  logic [15:0] cnt_q, cnt_d;
  logic        start_mem_q, start_pe_q, busy_q, done_q;

  // Next-state, loop-index and coordinate update logic.
  always_comb begin
    state_d = state_q;
    xi_d    = xi_q;
    yi_d    = yi_q;
    zi_d    = zi_q;
    x_d     = x_q;
    y_d     = y_q;
    z_d     = z_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = MEM_GO;
          xi_d    = 16'd0;
          yi_d    = 16'd0;
          zi_d    = 16'd0;
          x_d     = 8'd0;
          y_d     = 8'd0;
          z_d     = 8'd0;
          cnt_d   = 16'd0;
        end else begin
          state_d = IDLE;
        end
      end
      MEM_GO: state_d = MEM_WAIT;
      MEM_WAIT: begin
        if (done_mem_l1) begin
          state_d = PE_GO;
        end else begin
          state_d = MEM_WAIT;
        end
      end
      PE_GO: state_d = PE_WAIT;
      PE_WAIT: begin
        if (done_pe_l1) begin
          state_d = ADV;
          cnt_d   = cnt_q + 16'd1;
        end else begin
          state_d = PE_WAIT;
        end
      end
      ADV: begin
        if ((xi_q == X_LAST) && (yi_q == Y_LAST) && (zi_q == Z_LAST)) begin
          state_d = FIN;
        end else begin
          state_d = MEM_GO;
          // x is innermost; each wrap carries into the next loop level.
          if (xi_q != X_LAST) begin
            xi_d = xi_q + 16'd1;
            x_d  = x_q + X_INC;
          end else begin
            xi_d = 16'd0;
            x_d  = 8'd0;
            if (yi_q != Y_LAST) begin
              yi_d = yi_q + 16'd1;
              y_d  = y_q + Y_INC;
            end else begin
              yi_d = 16'd0;
              y_d  = 8'd0;
              zi_d = zi_q + 16'd1;
              z_d  = z_q + Z_INC;
            end
          end
        end
      end
      FIN:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State, index and counter registers; output flags decoded from next state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      xi_q        <= 16'd0;
      yi_q        <= 16'd0;
      zi_q        <= 16'd0;
      x_q         <= 8'd0;
      y_q         <= 8'd0;
      z_q         <= 8'd0;
      cnt_q       <= 16'd0;
      start_mem_q <= 1'b0;
      start_pe_q  <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      xi_q        <= xi_d;
      yi_q        <= yi_d;
      zi_q        <= zi_d;
      x_q         <= x_d;
      y_q         <= y_d;
      z_q         <= z_d;
      cnt_q       <= cnt_d;
      start_mem_q <= (state_d == MEM_GO);
      start_pe_q  <= (state_d == PE_GO);
      busy_q      <= (state_d != IDLE);
      done_q      <= (state_d == FIN);
    end
  end

  assign start_mem_l1 = start_mem_q;
  assign start_pe_l1  = start_pe_q;
  assign x            = x_q;
  assign y            = y_q;
  assign z            = z_q;
  assign tile_cnt     = cnt_q;
  assign busy         = busy_q;
  assign done         = done_q;

endmodule
